// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for a CIC decimator: input handshake, rate-R comb strobe,
// comb warm-up suppression, output handshake and sticky overflow. Macro CIC_DECIM_CTRL_RATE_PROG_EN adds a runtime ratio port.
module cic_decim_ctrl #(
    parameter int R        = 4,
    parameter int N_STAGES = 3,
    parameter int N_DELAYS = 1,
    parameter int WARM_CNT = N_STAGES * N_DELAYS
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    integ_en,
    output logic                    comb_en,
    input  logic [N_STAGES-1:0]     comb_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    input  logic                    ovf_clr,
    output logic                    ovf_sticky,
`ifdef CIC_DECIM_CTRL_RATE_PROG_EN
    input  logic [$clog2(R+1)-1:0]  rate,
`endif
    output logic                    warm
);

    localparam int CW = $clog2(R);
    localparam int WW = (WARM_CNT > 0) ? $clog2(WARM_CNT + 1) : 1;
    localparam logic [WW-1:0] WARM_LAST = WW'((WARM_CNT > 0) ? WARM_CNT - 1 : 0);

    typedef enum logic {WARMUP, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] dec_cnt_q, dec_cnt_d;
    logic [WW-1:0] warm_cnt_q, warm_cnt_d;
    logic          comb_en_q, comb_en_d;
    logic          out_valid_q, out_valid_d;
    logic          warm_q, warm_d;
    logic          ovf_q, ovf_d;
    logic          live_q;
    logic          accept;
    logic          wrap;

`ifdef CIC_DECIM_CTRL_RATE_PROG_EN
    localparam int RW = $clog2(R + 1);

    logic [RW-1:0] rate_q, rate_d;

    function automatic logic [RW-1:0] sat_rate(input logic [RW-1:0] r);
        if (r < RW'(2)) return RW'(2);
        if (r > RW'(R)) return RW'(R);
        return r;
    endfunction

    // live_q is low only in the first cycle after reset release, when no sample can be accepted
    assign rate_d = (!live_q || flush) ? sat_rate(rate) : rate_q;
    assign wrap   = (RW'(dec_cnt_q) == rate_q - RW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rate_q <= RW'(R);
        else       rate_q <= rate_d;
    end
`else
    assign wrap = (dec_cnt_q == CW'(R - 1));
`endif

    assign in_ready   = live_q & ~flush & ~(out_valid_q & ~out_ready);
    assign accept     = in_valid & in_ready;
    assign integ_en   = accept;
    assign comb_en    = comb_en_q;
    assign out_valid  = out_valid_q;
    assign warm       = warm_q;
    assign ovf_sticky = ovf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= WARMUP;
            dec_cnt_q   <= '0;
            warm_cnt_q  <= '0;
            comb_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            warm_q      <= 1'b0;
            ovf_q       <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_cnt_q   <= dec_cnt_d;
            warm_cnt_q  <= warm_cnt_d;
            comb_en_q   <= comb_en_d;
            out_valid_q <= out_valid_d;
            warm_q      <= warm_d;
            ovf_q       <= ovf_d;
            live_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        dec_cnt_d   = dec_cnt_q;
        warm_cnt_d  = warm_cnt_q;
        comb_en_d   = 1'b0;
        out_valid_d = out_valid_q;
        warm_d      = warm_q;
        ovf_d       = ovf_q;

        // out_valid is only ever high in RUN, so warm-up overflow never reaches the flag
        if (out_valid_q && (|comb_ovf)) ovf_d = 1'b1;
        else if (ovf_clr)               ovf_d = 1'b0;

        if (flush) begin
            state_d     = WARMUP;
            dec_cnt_d   = '0;
            warm_cnt_d  = '0;
            out_valid_d = 1'b0;
            warm_d      = 1'b0;
        end else begin
            if (accept) begin
                if (wrap) begin
                    dec_cnt_d = '0;
                    comb_en_d = 1'b1;
                end else begin
                    dec_cnt_d = dec_cnt_q + CW'(1);
                end
            end
            if (out_valid_q && out_ready) out_valid_d = 1'b0;
            unique case (state_q)
                WARMUP: begin
                    if (comb_en_q) begin
                        warm_cnt_d = warm_cnt_q + WW'(1);
                        if (warm_cnt_q == WARM_LAST) begin
                            state_d = RUN;
                            warm_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (comb_en_q) out_valid_d = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl: strobe/output timing scoreboards, backpressure,
// overflow flag, flush, mid-stream reset and (when CIC_DECIM_CTRL_RATE_PROG_EN is defined) runtime ratio.
module tb_cic_decim_ctrl;

    localparam int R        = 4;
    localparam int N_STAGES = 3;
    localparam int N_DELAYS = 1;
    localparam int WARM_CNT = N_STAGES * N_DELAYS;

    logic                clk       = 1'b0;
    logic                rstn      = 1'b0;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b1;
    logic                flush     = 1'b0;
    logic                ovf_clr   = 1'b0;
    logic [N_STAGES-1:0] comb_ovf  = '0;
    logic                in_ready, integ_en, comb_en, out_valid, ovf_sticky, warm;
`ifdef CIC_DECIM_CTRL_RATE_PROG_EN
    logic [$clog2(R+1)-1:0] rate = ($clog2(R+1))'(R);
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    cic_decim_ctrl #(
        .R        (R),
        .N_STAGES (N_STAGES),
        .N_DELAYS (N_DELAYS),
        .WARM_CNT (WARM_CNT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .integ_en   (integ_en),
        .comb_en    (comb_en),
        .comb_ovf   (comb_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
`ifdef CIC_DECIM_CTRL_RATE_PROG_EN
        .rate       (rate),
`endif
        .warm       (warm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, want completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b1;
        #12;
        vectors++;
        if ({in_ready, integ_en, comb_en, out_valid, ovf_sticky, warm} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, want 000000",
                     {in_ready, integ_en, comb_en, out_valid, ovf_sticky, warm});
        end
        @(negedge clk); rstn = 1'b1; in_valid = 1'b0;
        @(posedge clk); #2;
        vectors++;
        if (in_ready !== 1'b1 || warm !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b warm=%b, want 1/0", in_ready, warm);
        end
    endtask

    task automatic test_decimation();
        int n, strobes;
        int qc[$];
        int qo[$];
        n = 0; strobes = 0;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk); #1;
            in_valid = (n < 20); out_ready = 1'b1; #1;
            vectors++;
            if (in_ready !== 1'b1 || integ_en !== in_valid) begin
                miscompares++;
                $display("FAIL dec_handshake: in_ready=%b integ_en=%b, want 1/%b", in_ready, integ_en, in_valid);
            end
            if (comb_en === 1'b1) begin
                strobes++;
                vectors++;
                if (qc.size() == 0 || qc[0] != cyc) begin
                    miscompares++;
                    $display("FAIL dec_comb_en: pulse at cycle %0d, want %0d", cyc, (qc.size() == 0) ? -1 : qc[0]);
                end
                if (qc.size() != 0) void'(qc.pop_front());
                if (strobes <= WARM_CNT) begin
                    vectors++;
                    if (warm !== 1'b0) begin
                        miscompares++;
                        $display("FAIL dec_warm_early: warm=%b at strobe %0d, want 0", warm, strobes);
                    end
                end
            end
            if (out_valid === 1'b1) begin
                vectors++;
                if (qo.size() == 0 || qo[0] != cyc || warm !== 1'b1) begin
                    miscompares++;
                    $display("FAIL dec_out_valid: cycle %0d warm=%b, want cycle %0d warm=1",
                             cyc, warm, (qo.size() == 0) ? -1 : qo[0]);
                end
                if (qo.size() != 0) void'(qo.pop_front());
            end
            if ((in_valid & in_ready) === 1'b1) begin
                n++;
                if (n % R == 0) begin
                    qc.push_back(cyc + 1);
                    if (n / R > WARM_CNT) qo.push_back(cyc + 2);
                end
            end
        end
        vectors++;
        if (qc.size() != 0 || qo.size() != 0) begin
            miscompares++;
            $display("FAIL dec_missing: %0d comb_en and %0d out_valid pending, want 0/0", qc.size(), qo.size());
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b0; #1;
            seen = (out_valid === 1'b1);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL bp_timeout: out_valid=%b after 20 cycles, want 1", out_valid);
        end
        for (int s = 0; s < 5; s++) begin
            if (s != 0) begin @(posedge clk); #2; end
            vectors++;
            if ({in_ready, integ_en, comb_en, out_valid} !== 4'b0001) begin
                miscompares++;
                $display("FAIL bp_stall%0d: ready/integ/comb/valid=%b, want 0001", s,
                         {in_ready, integ_en, comb_en, out_valid});
            end
        end
        @(posedge clk); #1; out_ready = 1'b1; #1;
        vectors++;
        if ({in_ready, integ_en, out_valid} !== 3'b111) begin
            miscompares++;
            $display("FAIL bp_release: ready/integ/valid=%b, want 111", {in_ready, integ_en, out_valid});
        end
        @(posedge clk); #1; in_valid = 1'b0; #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_after_transfer: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        bit [2:0] ovf_v [3] = '{3'b010, 3'b010, 3'b000};
        bit       clr_v [3] = '{1'b0, 1'b1, 1'b1};
        bit       exp_v [3] = '{1'b1, 1'b1, 1'b0};
        bit seen, any_ov;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b0; #1;
            seen = (out_valid === 1'b1);
        end
        vectors++;
        if (!seen || ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_setup: out_valid=%b ovf_sticky=%b, want 1/0", out_valid, ovf_sticky);
        end
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1; in_valid = 1'b0; comb_ovf = ovf_v[s]; ovf_clr = clr_v[s]; #1;
            @(posedge clk); #1; comb_ovf = '0; ovf_clr = 1'b0; #1;
            vectors++;
            if (ovf_sticky !== exp_v[s]) begin
                miscompares++;
                $display("FAIL ovf_step%0d: ovf_sticky=%b, want %b", s, ovf_sticky, exp_v[s]);
            end
        end
        @(posedge clk); #1; out_ready = 1'b1; #1;
        @(posedge clk); #1; flush = 1'b1; #1;
        @(posedge clk); #1; flush = 1'b0; #1;
        any_ov = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1; in_valid = 1'b1; comb_ovf = '1; #1;
            if (out_valid === 1'b1) any_ov = 1'b1;
        end
        @(posedge clk); #1; in_valid = 1'b0; comb_ovf = '0; #1;
        vectors++;
        if (any_ov || ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_warmup: out_valid_seen=%b ovf_sticky=%b, want 0/0", any_ov, ovf_sticky);
        end
    endtask

    task automatic test_flush();
        bit seen;
        int n;
        int qc[$];
        int qo[$];
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b0; #1;
            seen = (out_valid === 1'b1);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL flush_setup_timeout: out_valid=%b, want 1", out_valid);
        end
        @(posedge clk); #1; in_valid = 1'b0; comb_ovf = 3'b001; #1;
        @(posedge clk); #1; comb_ovf = '0; out_ready = 1'b1; #1;
        n = 0;
        for (int k = 0; k < 20 && n < 6; k++) begin
            @(posedge clk); #1; in_valid = 1'b1; #1;
            if ((in_valid & in_ready) === 1'b1) n++;
        end
        @(posedge clk); #1; flush = 1'b1; in_valid = 1'b1; #1;
        vectors++;
        if (in_ready !== 1'b0 || integ_en !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_cycle: in_ready=%b integ_en=%b, want 0/0", in_ready, integ_en);
        end
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0; #1;
        vectors++;
        if ({warm, out_valid, comb_en, ovf_sticky} !== 4'b0001) begin
            miscompares++;
            $display("FAIL flush_state: warm/valid/comb/sticky=%b, want 0001", {warm, out_valid, comb_en, ovf_sticky});
        end
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            in_valid = (n < 15) || (n == 15 && c >= 19); #1;
            if (comb_en === 1'b1) begin
                vectors++;
                if (qc.size() == 0 || qc[0] != cyc) begin
                    miscompares++;
                    $display("FAIL flush_comb_en: pulse at cycle %0d, want %0d", cyc, (qc.size() == 0) ? -1 : qc[0]);
                end
                if (qc.size() != 0) void'(qc.pop_front());
            end
            if (out_valid === 1'b1) begin
                vectors++;
                if (qo.size() == 0 || qo[0] != cyc) begin
                    miscompares++;
                    $display("FAIL flush_out_valid: cycle %0d after %0d accepts, want cycle %0d", cyc, n,
                             (qo.size() == 0) ? -1 : qo[0]);
                end
                if (qo.size() != 0) void'(qo.pop_front());
            end
            if ((in_valid & in_ready) === 1'b1) begin
                n++;
                if (n % R == 0) begin
                    qc.push_back(cyc + 1);
                    if (n / R > WARM_CNT) qo.push_back(cyc + 2);
                end
            end
        end
        vectors++;
        if (qc.size() != 0 || qo.size() != 0) begin
            miscompares++;
            $display("FAIL flush_missing: %0d comb_en and %0d out_valid pending, want 0/0", qc.size(), qo.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n, strobes;
        int qc[$];
        int qo[$];
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b0; #1;
            seen = (out_valid === 1'b1);
        end
        @(posedge clk); #1; comb_ovf = 3'b100; #1;
        @(posedge clk); #1; comb_ovf = '0; #1;
        vectors++;
        if (!seen || out_valid !== 1'b1 || ovf_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_setup: seen=%b out_valid=%b ovf_sticky=%b, want 1/1/1", seen, out_valid, ovf_sticky);
        end
        #2; rstn = 1'b0; #1;
        vectors++;
        if ({in_ready, integ_en, comb_en, out_valid, ovf_sticky, warm} !== 6'b0) begin
            miscompares++;
            $display("FAIL rst_async: outputs=%b, want 000000", {in_ready, integ_en, comb_en, out_valid, ovf_sticky, warm});
        end
        @(negedge clk); rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #2;
        vectors++;
        if ({in_ready, out_valid, warm} !== 3'b100) begin
            miscompares++;
            $display("FAIL rst_release: ready/valid/warm=%b, want 100", {in_ready, out_valid, warm});
        end
        n = 0; strobes = 0;
        for (int c = 0; c < 22; c++) begin
            @(posedge clk); #1;
            in_valid = (n < 16); out_ready = 1'b1; #1;
            if (comb_en === 1'b1) begin
                strobes++;
                vectors++;
                if (qc.size() == 0 || qc[0] != cyc || (strobes <= WARM_CNT && warm !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL rst_comb_en: pulse at cycle %0d warm=%b, want cycle %0d", cyc, warm,
                             (qc.size() == 0) ? -1 : qc[0]);
                end
                if (qc.size() != 0) void'(qc.pop_front());
            end
            if (out_valid === 1'b1) begin
                vectors++;
                if (qo.size() == 0 || qo[0] != cyc) begin
                    miscompares++;
                    $display("FAIL rst_out_valid: cycle %0d, want %0d", cyc, (qo.size() == 0) ? -1 : qo[0]);
                end
                if (qo.size() != 0) void'(qo.pop_front());
            end
            if ((in_valid & in_ready) === 1'b1) begin
                n++;
                if (n % R == 0) begin
                    qc.push_back(cyc + 1);
                    if (n / R > WARM_CNT) qo.push_back(cyc + 2);
                end
            end
        end
        vectors++;
        if (qc.size() != 0 || qo.size() != 0) begin
            miscompares++;
            $display("FAIL rst_missing: %0d comb_en and %0d out_valid pending, want 0/0", qc.size(), qo.size());
        end
    endtask

`ifdef CIC_DECIM_CTRL_RATE_PROG_EN
    task automatic test_rate();
        int n, ratio, accepts;
        int qc[$];
        for (int p = 0; p < 2; p++) begin
            // second pass uses the largest encodable ratio, which lies above R
            if (p == 0) begin rate = ($clog2(R+1))'(2); ratio = 2; accepts = 8;  end
            else        begin rate = '1;                ratio = R; accepts = 12; end
            @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; #1;
            @(posedge clk); #1; flush = 1'b0; #1;
            n = 0;
            for (int c = 0; c < accepts + 4; c++) begin
                @(posedge clk); #1;
                in_valid = (n < accepts); #1;
                if (comb_en === 1'b1) begin
                    vectors++;
                    if (qc.size() == 0 || qc[0] != cyc) begin
                        miscompares++;
                        $display("FAIL rate%0d_comb_en: pulse at cycle %0d, want %0d", ratio, cyc,
                                 (qc.size() == 0) ? -1 : qc[0]);
                    end
                    if (qc.size() != 0) void'(qc.pop_front());
                end
                if ((in_valid & in_ready) === 1'b1) begin
                    n++;
                    if (n % ratio == 0) qc.push_back(cyc + 1);
                end
            end
            vectors++;
            if (qc.size() != 0) begin
                miscompares++;
                $display("FAIL rate%0d_missing: %0d comb_en pending, want 0", ratio, qc.size());
            end
            qc.delete();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_decimation();
        test_backpressure();
        test_overflow();
        test_flush();
        test_reset_mid();
`ifdef CIC_DECIM_CTRL_RATE_PROG_EN
        test_rate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
